// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 16-bit pipeline: load-use bubbles, branch squash, data-memory waits.
// Define PIPE_HAZARD_CTRL_PERF_EN to add saturating stall/flush/bubble performance counters.
module pipe_hazard_ctrl #(
    parameter int REG_W        = 4,
    parameter int FLUSH_CYCLES = 1,
    parameter int PERF_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic [1:0]       ctrl_state
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_flushes,
    output logic [PERF_W-1:0] perf_ld_bubbles
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        FLUSH   = 2'b01,
        MEMWAIT = 2'b10
    } state_e;

    localparam logic [3:0] FCNT_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
        $error("FLUSH_CYCLES must be in 1..15");
    end
    if (PERF_W < 1) begin : g_bad_perf_w
        $error("PERF_W must be at least 1");
    end

    state_e     state_q, state_d;
    logic [3:0] fcnt_q, fcnt_d;
    logic       memstall;
    logic       loaduse;
    logic       run_eval;

    assign memstall = mem_req & ~mem_ack;
    assign loaduse  = ex_memread &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) |
                       (id_use_rs2 & (id_rs2 == ex_rd)));

    assign ctrl_state = state_q;

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_bubble = 1'b0;
        exmem_en    = 1'b1;
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        run_eval    = 1'b0;

        case (state_q)
            MEMWAIT: begin
                // EX and ID are held, so branch/load-use only count once the access completes
                if (!mem_ack) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                end else begin
                    state_d  = RUN;
                    run_eval = 1'b1;
                end
            end
            FLUSH: begin
                if (memstall) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                end else if (ex_branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    fcnt_d      = FCNT_RELOAD;
                end else begin
                    ifid_flush = 1'b1;
                    fcnt_d     = fcnt_q - 4'd1;
                    if (fcnt_q <= 4'd1) begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                // RUN, and the unused encoding which behaves as RUN
                if (memstall) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    state_d  = MEMWAIT;
                end else begin
                    run_eval = 1'b1;
                end
            end
        endcase

        if (run_eval) begin
            if (ex_branch_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                if (MULTI_FLUSH) begin
                    state_d = FLUSH;
                    fcnt_d  = FCNT_RELOAD;
                end
            end else if (loaduse) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
            end
        end

        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_en     = 1'b0;
            idex_bubble = 1'b1;
            exmem_en    = 1'b0;
            state_d     = RUN;
            fcnt_d      = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            fcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [PERF_W-1:0] perf_stall_q;
    logic [PERF_W-1:0] perf_flush_q;
    logic [PERF_W-1:0] perf_ldb_q;
    logic              branch_ev;
    logic              ldb_ev;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + PERF_W'(1);
    endfunction

    // Flush+bubble only coincide on an acted-on branch; held IF/ID plus bubble only on a load-use
    assign branch_ev = ifid_flush & idex_bubble;
    assign ldb_ev    = ~ifid_en & idex_bubble;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
            perf_ldb_q   <= '0;
        end else begin
            if (memstall | loaduse) perf_stall_q <= sat_inc(perf_stall_q);
            if (branch_ev)          perf_flush_q <= sat_inc(perf_flush_q);
            if (ldb_ev)             perf_ldb_q   <= sat_inc(perf_ldb_q);
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flushes      = perf_flush_q;
    assign perf_ld_bubbles   = perf_ldb_q;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 16-bit pipelined CPU.
- Drives the enable, flush and bubble controls of the PC and of the IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves three hazard classes:
  - load-use data hazards,
  - taken-branch control hazards, with a configurable squash depth,
  - multi-cycle data-memory waits, through a req/ack handshake.

Parameters:
- REG_W, 4: register-index width of the rs/rd compare ports.
- FLUSH_CYCLES, 1: cycles of fetch squash after a taken branch, legal range 1..15.
- PERF_W, 16: width of the performance counters; used only with the optional feature.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs1  in  REG_W  source register 1 of the instruction in ID.
- id_rs2  in  REG_W  source register 2 of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_memread  in  1  instruction in EX is a load.
- ex_rd  in  REG_W  destination register of the EX instruction.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- mem_req  in  1  MEM stage needs a data-memory access.
- mem_ack  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP (16'h0000).
- idex_en  out  1  ID/EX load enable.
- idex_bubble  out  1  ID/EX loads zeroed control fields.
- exmem_en  out  1  EX/MEM load enable.
- ctrl_state  out  2  current FSM state.

Behaviour:
- FSM states:
  - RUN = 2'b00
  - FLUSH = 2'b01
  - MEMWAIT = 2'b10
  - 2'b11 is unreachable and decodes as RUN.
- Registered state: FSM state, plus flush counter fcnt (4 bits).
- Outputs are combinational from state and current inputs. The hazard response therefore applies in the same cycle the hazard is visible.
- Reset:
  - While rst = 1, outputs are forced to: pc_en = 0, ifid_en = 0, idex_en = 0, exmem_en = 0, ifid_flush = 1, idex_bubble = 1.
  - At the clock edge: state <= RUN, fcnt <= 0.
  - Reset mid-operation overrides every state and any pending handshake.
- Defaults when no rule fires: all enables = 1, flush = 0, bubble = 0.
- Derived terms:
  - memstall = mem_req & ~mem_ack.
  - loaduse = ex_memread & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
  - Every register index, including r0, is compared.
- Rule priority, highest first: reset > memstall > branch > loaduse.
- RUN:
  - memstall: all four enables = 0, flush/bubble = 0; next state MEMWAIT.
  - Else ex_branch_taken:
    - pc_en = 1, so the branch target loads.
    - ifid_flush = 1, idex_bubble = 1.
    - If FLUSH_CYCLES > 1: next state FLUSH, fcnt <= FLUSH_CYCLES-1. Otherwise remain in RUN.
  - Else loaduse: pc_en = 0, ifid_en = 0, idex_bubble = 1, exmem_en = 1. This is exactly one bubble; remain in RUN.
- MEMWAIT:
  - While mem_ack = 0: all enables = 0.
  - ex_branch_taken and loaduse are ignored while frozen, because EX and ID are held.
  - On the mem_ack cycle: apply the RUN rules with memstall treated as 0, and move to the state those rules select.
  - A mem_req/mem_ack pair in the same RUN cycle causes no stall.
- FLUSH:
  - ifid_flush = 1, pc_en = 1.
  - fcnt decrements each unfrozen cycle; when fcnt == 1 in an unfrozen cycle, next state is RUN.
  - memstall: all enables = 0, ifid_flush = 0, fcnt holds, state stays FLUSH.
  - A new ex_branch_taken reloads fcnt with FLUSH_CYCLES-1 and applies the RUN branch outputs.
  - loaduse is ignored, because ID holds a squashed NOP.
- idex_bubble and idex_en = 1 together mean a bubble is inserted. ifid_flush takes precedence over ifid_en in the IF/ID register.

Optional Feature:
- Macro: PIPE_HAZARD_CTRL_PERF_EN.
- With the macro defined, three extra outputs are added, each PERF_W wide:
  - perf_stall_cycles: increments on every cycle with memstall or loaduse active.
  - perf_flushes: increments on each taken branch acted on.
  - perf_ld_bubbles: increments on each load-use bubble.
- Counter behaviour:
  - All three saturate at all-ones.
  - All three clear to 0 on rst.
  - Counting is independent of FSM state.
- Without the macro, the ports and logic are absent and the block behaviour is otherwise identical.

Test Plan:
1. Reset: rst = 1 for 2 cycles with mem_req = 1 → pc_en = 0, ifid_flush = 1, idex_bubble = 1, ctrl_state = 0. After release with no hazards → all enables = 1.
2. Load-use: ex_memread = 1, ex_rd = 3, id_rs2 = 3, id_use_rs2 = 1 → for one cycle pc_en = 0, ifid_en = 0, idex_bubble = 1. Next cycle (ex_memread = 0) → normal. Repeat with id_use_rs2 = 0 → no stall.
3. Branch, FLUSH_CYCLES = 3: ex_branch_taken = 1 in RUN → ifid_flush = 1, idex_bubble = 1, then FLUSH for 2 cycles with ifid_flush = 1, then RUN.
4. Memory wait: mem_req = 1, mem_ack = 0 for 4 cycles, then ack → all enables = 0 for 4 cycles, ctrl_state = 2, enables = 1 on the ack cycle, RUN afterwards. mem_req = mem_ack = 1 together → zero stall cycles.
5. Simultaneous events: memstall + ex_branch_taken + loaduse in the same cycle → freeze only. On the ack cycle → branch flush applied, no load-use bubble.
6. PERF_EN: 3 load-use bubbles, 2 branches, 5 memstall cycles → perf_ld_bubbles = 3, perf_flushes = 2, perf_stall_cycles = 8. Force a counter to all-ones → it holds.
